// File: rtl/btn_event_arbiter_pkg.sv
// Shared definitions for the button event arbiter.
//   BTN_N / BTN_IDW : default requester count and event id width
//   arb_state_t     : arbiter state encoding (IDLE, OFFER)
//   P1_UP..P2_DN    : button index assignments on the btn vector
package btn_event_arbiter_pkg;

  localparam int BTN_N   = 4;
  localparam int BTN_IDW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int P1_UP = 0;
  localparam int P1_DN = 1;
  localparam int P2_UP = 2;
  localparam int P2_DN = 3;

endpackage

// File: rtl/btn_event_arbiter_edge.sv
// N-bit two-flop rising-edge detector.
//   clk   : system clock
//   reset : asynchronous active-low reset, clears both flop stages
//   din   : synchronized button levels
//   rise  : one-cycle pulse per low-to-high transition of din[i]
module btn_event_arbiter_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      logic d1_reg;
      logic d2_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          d1_reg <= 1'b0;
          d2_reg <= 1'b0;
        end else begin
          d1_reg <= din[gi];
          d2_reg <= d1_reg;
        end
      end

      assign rise[gi] = d1_reg & ~d2_reg;
    end
  endgenerate

endmodule

// File: rtl/btn_event_arbiter.sv
// Round-robin arbiter sharing one event path among N button requesters.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   btn       : synchronized button levels, bit i = requester i
//   evt_valid : an event is offered to the consumer
//   evt_id    : index of the offered requester, stable while evt_valid=1
//   evt_ready : consumer accepts the offered event at this edge
//   pending   : registered pending-event flags
//   lost      : sticky flags, press dropped because pending[i] was already set
//   lost_clr  : clears all lost flags (a same-cycle new loss still sets)
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter int N   = BTN_N,
  parameter int IDW = BTN_IDW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   lost,
  input  logic           lost_clr
);

  logic [N-1:0]   rise;
  arb_state_t     state_reg, state_next;
  logic [N-1:0]   pending_reg, pending_next;
  logic [N-1:0]   lost_reg, lost_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] evt_id_reg, evt_id_next;

  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic           found;
  logic           grant_fire;
  logic [N-1:0]   grant;

  btn_event_arbiter_edge #(.N(N)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (btn),
    .rise  (rise)
  );

  // Round-robin search starting at ptr_reg, wrapping modulo N.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(ptr_reg) + k) % N);
      if (!found && pending_reg[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // A new grant is possible when idle, or when the current offer is being
  // accepted this edge (back-to-back hand-over without a bubble).
  always_comb begin
    grant_fire = found && ((state_reg == IDLE) || evt_ready);
    grant      = '0;
    if (grant_fire) begin
      grant[winner] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_fire) state_next = OFFER;
      OFFER:   if (evt_ready && !grant_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Rise wins over grant-clear, so a press on the id being granted re-pends.
    pending_next = (pending_reg & ~grant) | rise;
    lost_next    = (lost_clr ? '0 : lost_reg) | (rise & pending_reg & ~grant);
    ptr_next     = grant_fire ? IDW'((int'(winner) + 1) % N) : ptr_reg;
    evt_id_next  = grant_fire ? winner : evt_id_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      lost_reg    <= '0;
      ptr_reg     <= '0;
      evt_id_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      lost_reg    <= lost_next;
      ptr_reg     <= ptr_next;
      evt_id_reg  <= evt_id_next;
    end
  end

  assign evt_valid = (state_reg == OFFER);
  assign evt_id    = evt_id_reg;
  assign pending   = pending_reg;
  assign lost      = lost_reg;

endmodule

// File: tb/tb_btn_event_arbiter.sv
module tb_btn_event_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_ready;
  logic [3:0] pending;
  logic [3:0] lost;
  logic       lost_clr;

  int total  = 0;
  int passed = 0;

  // Reference model: button history, event flags and the offer in progress.
  bit m_h1[N];
  bit m_h2[N];
  bit m_pend[N];
  bit m_lost[N];
  bit m_off;
  int m_id;
  int m_last;   // last granted requester; search resumes just after it

  int ids[16];
  int nids;
  int first_v;
  int vcount;

  btn_event_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_ready (evt_ready),
    .pending   (pending),
    .lost      (lost),
    .lost_clr  (lost_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input bit v[N]);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_h1[i] = 0; m_h2[i] = 0; m_pend[i] = 0; m_lost[i] = 0;
    end
    m_off  = 0;
    m_id   = 0;
    m_last = N - 1;
  endtask

  task automatic model_edge();
    bit r[N];
    int g = -1;
    for (int i = 0; i < N; i++) r[i] = m_h1[i] && !m_h2[i];
    if (!m_off || evt_ready) begin
      for (int k = 1; k <= N; k++) begin
        int j = (m_last + k) % N;
        if (g < 0 && m_pend[j]) g = j;
      end
    end
    for (int i = 0; i < N; i++) begin
      bit dropped = r[i] && m_pend[i] && (i != g);
      m_lost[i] = (lost_clr ? 1'b0 : m_lost[i]) | dropped;
      if (r[i])        m_pend[i] = 1;
      else if (i == g) m_pend[i] = 0;
    end
    if (g >= 0) begin
      m_off = 1; m_id = g; m_last = g;
    end else if (m_off && evt_ready) begin
      m_off = 0;
    end
    for (int i = 0; i < N; i++) begin
      m_h2[i] = m_h1[i];
      m_h1[i] = btn[i];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},   32'(evt_valid), 32'(m_off));
    check({tag, ".id"},      32'(evt_id),    32'(m_id));
    check({tag, ".pending"}, 32'(pending),   pack(m_pend));
    check({tag, ".lost"},    32'(lost),      pack(m_lost));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    $display("t=%0t %s btn=%b rdy=%0d clr=%0d -> valid=%0d id=%0d pend=%b lost=%b",
             $time, tag, btn, evt_ready, lost_clr, evt_valid, evt_id, pending, lost);
    check_all(tag);
  endtask

  task automatic pulse(input logic [3:0] v, input string tag);
    btn = v;
    tick(tag);
    btn = 4'b0000;
    tick(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; btn = '0; evt_ready = 1'b0; lost_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",   32'(evt_valid), 32'd0);
    check("rst.id",      32'(evt_id),    32'd0);
    check("rst.pending", 32'(pending),   32'd0);
    check("rst.lost",    32'(lost),      32'd0);
    reset = 1'b1;

    // Single held press: exactly one event for id 2, three edges after btn rises.
    evt_ready = 1'b1;
    btn = 4'b0100;
    vcount = 0; first_v = -1; nids = 0;
    for (int i = 0; i < 10; i++) begin
      tick("held");
      if (evt_valid) begin
        vcount++;
        if (first_v < 0) first_v = i + 1;
        ids[0] = evt_id;
      end
    end
    check("held.pulses",  vcount,       1);
    check("held.latency", first_v,      3);
    check("held.id",      ids[0],       2);
    check("held.pending", 32'(pending), 32'd0);
    check("held.lost",    32'(lost),    32'd0);
    btn = 4'b0000;
    tick("held");

    // All four together: ids 0,1,2,3 on consecutive cycles.
    do_reset();
    btn = 4'b1111;
    nids = 0; first_v = -1;
    for (int i = 0; i < 10; i++) begin
      tick("all4");
      if (evt_valid && nids < 16) begin
        if (first_v < 0) first_v = i;
        ids[nids] = evt_id;
        nids++;
      end
    end
    check("all4.count", nids, 4);
    for (int k = 0; k < 4; k++) check("all4.order", ids[k], k);
    check("all4.valid_end", 32'(evt_valid), 32'd0);
    btn = 4'b0000;
    tick("all4");

    // Offer held without ready; re-press re-pends, third press is lost.
    evt_ready = 1'b0;
    pulse(4'b0010, "hold");
    tick("hold");
    check("hold.valid",   32'(evt_valid), 32'd1);
    check("hold.id",      32'(evt_id),    32'd1);
    check("hold.pending", 32'(pending),   32'd0);
    pulse(4'b0010, "hold");
    check("hold.repend",  32'(pending),   32'b0010);
    check("hold.id2",     32'(evt_id),    32'd1);
    pulse(4'b0010, "hold");
    check("hold.lost",    32'(lost),      32'b0010);
    lost_clr = 1'b1;
    tick("hold");
    lost_clr = 1'b0;
    check("hold.lostclr", 32'(lost),      32'd0);
    evt_ready = 1'b1;
    repeat (4) tick("hold");
    check("hold.drained", 32'(evt_valid), 32'd0);

    // Wrap: after granting 3, presses on 0 and 2 come out 0 then 2.
    pulse(4'b1000, "wrap");
    repeat (3) tick("wrap");
    pulse(4'b0101, "wrap");
    nids = 0;
    for (int i = 0; i < 6; i++) begin
      tick("wrap");
      if (evt_valid && nids < 16) begin
        ids[nids] = evt_id;
        nids++;
      end
    end
    check("wrap.count",  nids,   2);
    check("wrap.first",  ids[0], 0);
    check("wrap.second", ids[1], 2);

    // Rise on 0 in the same edge that 0 is granted.
    evt_ready = 1'b0;
    pulse(4'b0010, "same");
    tick("same");
    pulse(4'b0001, "same");
    tick("same");
    btn = 4'b0001;
    tick("same");
    evt_ready = 1'b1;
    tick("same");
    check("same.id",      32'(evt_id),    32'd0);
    check("same.pending", 32'(pending),   32'b0001);
    check("same.lost",    32'(lost),      32'd0);
    tick("same");
    check("same.again",   32'(evt_valid), 32'd1);
    check("same.id2",     32'(evt_id),    32'd0);
    btn = 4'b0000;
    repeat (3) tick("same");

    // Asynchronous reset while an event is offered.
    evt_ready = 1'b0;
    pulse(4'b0100, "arst");
    tick("arst");
    pulse(4'b1010, "arst");
    pulse(4'b1000, "arst");
    check("arst.pre_valid",   32'(evt_valid), 32'd1);
    check("arst.pre_id",      32'(evt_id),    32'd2);
    check("arst.pre_pending", 32'(pending),   32'b1010);
    check("arst.pre_lost",    32'(lost),      32'b1000);
    reset = 1'b0;
    #2;
    check("arst.valid",   32'(evt_valid), 32'd0);
    check("arst.id",      32'(evt_id),    32'd0);
    check("arst.pending", 32'(pending),   32'd0);
    check("arst.lost",    32'(lost),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    evt_ready = 1'b1;
    repeat (5) tick("arst.after");
    check("arst.quiet", 32'(evt_valid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) btn = 4'($urandom_range(0, 15));
      evt_ready = ($urandom_range(0, 3) != 0);
      lost_clr  = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
